data_stack_unit: RTL and testbench
==================================

Name: data_stack_unit

Overview:
- LIFO data stack for the stack-machine core.
- It is the responder side of the push_stack / pop_stack / rst_stack / stack_data command interface that the control FSM drives.
- Stores 16-bit operands, returns the popped word one cycle after the pop command, and publishes the top-of-stack pointer and full/empty status.
- Has a fault state: a stack error halts stack activity until the stack is reset.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 32, number of stack entries; must be a power of 2 and ≥ 2.
- PTR_W, $clog2(DEPTH)+1, width of the pointer; it can represent 0..DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rst_stack  in  1  synchronous stack clear, one-cycle pulse.
- push_stack  in  1  push command; samples stack_data.
- pop_stack  in  1  pop command.
- stack_data  in  WIDTH  word to push.
- data_out  out  WIDTH  popped word, registered.
- data_valid  out  1  one-cycle pulse; data_out holds a new popped word.
- tos_pointer  out  PTR_W  number of valid entries (sp).
- empty  out  1  sp == 0.
- full  out  1  sp == DEPTH.
- overflow_err  out  1  sticky: push attempted while full.
- underflow_err  out  1  sticky: pop attempted while empty.
- fault  out  1  block is in state FAULT.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high on rst.
- Reset values: state = RUN, sp = 0, data_out = 0, data_valid = 0, overflow_err = 0, underflow_err = 0. Array contents are not reset.
- rst_stack (synchronous) has the highest priority after rst. It has the same effect as rst and is taken in either state. A push or pop in the same cycle is ignored.
- States: RUN and FAULT.
  - RUN -> FAULT on any illegal command (see the error rows below).
  - FAULT -> RUN only on rst_stack or rst.
  - In FAULT every push and pop is ignored; sp, data_out and the array are frozen, and data_valid = 0.
- data_valid defaults to 0 every cycle unless a pop completes.
- RUN command decode, for each {push, pop} combination:
  - 00: no change.
  - 10, not full: mem[sp] <= stack_data; sp <= sp+1.
  - 10, full: push ignored; overflow_err <= 1; go to FAULT.
  - 01, not empty: data_out <= mem[sp-1]; sp <= sp-1; data_valid <= 1 next cycle. Pop-to-data latency is exactly 1 cycle.
  - 01, empty: pop ignored; data_out holds; underflow_err <= 1; go to FAULT.
  - 11, not empty (replace-top): data_out <= old mem[sp-1]; mem[sp-1] <= stack_data; sp unchanged; data_valid <= 1.
  - 11, empty: underflow_err <= 1; nothing is written; go to FAULT.
- Read-after-write: a pop in the cycle after a push returns the just-pushed word, because the array write completes on the push edge.
- Pointer: sp never wraps; it is saturated in [0, DEPTH] by the error rules. The write index is sp[PTR_W-2:0].
- Combinational flags: empty and full are derived from sp, tos_pointer = sp, and fault = (state == FAULT).
- Back-to-back commands on consecutive cycles are supported; no stall exists.

Optional Feature:
- Macro: DATA_STACK_PEEK_EN.
- Defined: adds two ports.
  - tos_peek  out  WIDTH: mem[sp-1] when sp ≥ 1, else 0.
  - nos_peek  out  WIDTH: mem[sp-2] when sp ≥ 2, else 0.
  - Both are combinational from the array and sp; they let the control FSM read operands without popping.
- Not defined: these ports and their read muxes do not exist. Behaviour is otherwise identical.

Decomposition:
- stack_pkg holds:
  - STACK_WIDTH = 16 and STACK_DEPTH = 32;
  - a stack_state_t enum {RUN, FAULT};
  - a stack_cmd_t encoding {NOP, PUSH, POP, REPLACE} = {push_stack, pop_stack}.
- One sub-module, stack_ram: DEPTH x WIDTH, one synchronous write port and one combinational read port; a second read port exists only under DATA_STACK_PEEK_EN.
- data_stack_unit holds the FSM, pointer, output register and error flags.

Test Plan:
- Push 0x0001, 0x0002, 0x0003, then pop three times -> data_out 0x0003, 0x0002, 0x0001, each with data_valid one cycle after the pop; tos_pointer 3 -> 0; empty = 1 at the end.
- Push 32 words 0x0100..0x011F -> full = 1, tos_pointer = 32. A 33rd push -> overflow_err = 1, fault = 1, sp stays 32. A following pop is ignored with data_valid = 0.
- Pop when empty after reset -> underflow_err = 1, fault = 1, data_out stays 0. Then rst_stack -> fault = 0, both errors 0, sp = 0.
- Push 0xAAAA, then push + pop together with 0x5555 -> data_out = 0xAAAA, data_valid = 1, sp stays 1. A following pop -> data_out = 0x5555.
- Push 0x1234 then pop on the next cycle -> data_out = 0x1234. Assert rst mid-sequence with sp = 5 -> all outputs return immediately (asynchronously) to reset values.
- With DATA_STACK_PEEK_EN, push 0x0011 and 0x0022 -> tos_peek = 0x0022, nos_peek = 0x0011. After one pop -> tos_peek = 0x0011, nos_peek = 0.

Source files
------------

// File: rtl/data_stack_unit_pkg.sv
// Shared types and sizes for the data stack unit.
// Optional macro DATA_STACK_PEEK_EN adds top/next-of-stack peek ports elsewhere.
package data_stack_unit_pkg;

    localparam int STACK_WIDTH = 16;
    localparam int STACK_DEPTH = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } stack_state_t;

    // Encoding is {push_stack, pop_stack}.
    typedef enum logic [1:0] {
        NOP     = 2'b00,
        POP     = 2'b01,
        PUSH    = 2'b10,
        REPLACE = 2'b11
    } stack_cmd_t;

endpackage

// File: rtl/data_stack_unit_if.sv
// Command/response bundle between the control FSM (master) and the data stack (slave).
// With DATA_STACK_PEEK_EN defined, tos_peek/nos_peek are carried as well.
interface data_stack_unit_if #(
    parameter int WIDTH = data_stack_unit_pkg::STACK_WIDTH,
    parameter int PTR_W = $clog2(data_stack_unit_pkg::STACK_DEPTH) + 1
);

    logic             rst_stack;
    logic             push_stack;
    logic             pop_stack;
    logic [WIDTH-1:0] stack_data;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic [PTR_W-1:0] tos_pointer;
    logic             empty;
    logic             full;
    logic             overflow_err;
    logic             underflow_err;
    logic             fault;
`ifdef DATA_STACK_PEEK_EN
    logic [WIDTH-1:0] tos_peek;
    logic [WIDTH-1:0] nos_peek;
`endif

    modport master (
        output rst_stack, push_stack, pop_stack, stack_data,
        input  data_out, data_valid, tos_pointer, empty, full,
               overflow_err, underflow_err, fault
`ifdef DATA_STACK_PEEK_EN
        , input tos_peek, nos_peek
`endif
    );

    modport slave (
        input  rst_stack, push_stack, pop_stack, stack_data,
        output data_out, data_valid, tos_pointer, empty, full,
               overflow_err, underflow_err, fault
`ifdef DATA_STACK_PEEK_EN
        , output tos_peek, nos_peek
`endif
    );

endinterface

// File: rtl/data_stack_unit_ram.sv
// Stack storage: one synchronous write port, one combinational read port,
// plus a second read port when DATA_STACK_PEEK_EN is defined.
module stack_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
`ifdef DATA_STACK_PEEK_EN
    ,
    input  logic [AW-1:0]    raddr2_i,
    output logic [WIDTH-1:0] rdata2_o
`endif
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately left unreset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

`ifdef DATA_STACK_PEEK_EN
    assign rdata2_o = mem_q[raddr2_i];
`endif

endmodule

// File: rtl/data_stack_unit.sv
// LIFO operand stack with RUN/FAULT state, sticky error flags and registered pop data.
// Optional macro DATA_STACK_PEEK_EN exposes combinational top/next-of-stack peeks.
module data_stack_unit
    import data_stack_unit_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic rst,
    data_stack_unit_if.slave stack_if
);

    localparam int AW = PTR_W - 1;

    stack_state_t     state_q;
    logic [PTR_W-1:0] sp_q;
    logic [WIDTH-1:0] dataOut_q;
    logic             dataValid_q;
    logic             overflowErr_q;
    logic             underflowErr_q;

    stack_cmd_t       cmd;
    logic             isEmpty;
    logic             isFull;
    logic             ramWe;
    logic [AW-1:0]    ramWaddr;
    logic [AW-1:0]    topAddr;
    logic [WIDTH-1:0] topData;

    assign cmd     = stack_cmd_t'({stack_if.push_stack, stack_if.pop_stack});
    assign isEmpty = (sp_q == '0);
    assign isFull  = (sp_q == PTR_W'(DEPTH));
    // Low-bit arithmetic wraps correctly at sp == DEPTH, where the index field is 0.
    assign topAddr = sp_q[AW-1:0] - AW'(1);

    assign ramWe = (state_q == RUN) && !stack_if.rst_stack &&
                   (((cmd == PUSH) && !isFull) || ((cmd == REPLACE) && !isEmpty));
    assign ramWaddr = (cmd == REPLACE) ? topAddr : sp_q[AW-1:0];

`ifdef DATA_STACK_PEEK_EN
    logic [WIDTH-1:0] nosData;

    stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk      (clk),
        .we_i     (ramWe),
        .waddr_i  (ramWaddr),
        .wdata_i  (stack_if.stack_data),
        .raddr_i  (topAddr),
        .rdata_o  (topData),
        .raddr2_i (sp_q[AW-1:0] - AW'(2)),
        .rdata2_o (nosData)
    );

    assign stack_if.tos_peek = (sp_q >= PTR_W'(1)) ? topData : '0;
    assign stack_if.nos_peek = (sp_q >= PTR_W'(2)) ? nosData : '0;
`else
    stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (ramWe),
        .waddr_i (ramWaddr),
        .wdata_i (stack_if.stack_data),
        .raddr_i (topAddr),
        .rdata_o (topData)
    );
`endif

    // rst_stack outranks every command; FAULT freezes everything until a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            sp_q           <= '0;
            dataOut_q      <= '0;
            dataValid_q    <= 1'b0;
            overflowErr_q  <= 1'b0;
            underflowErr_q <= 1'b0;
        end else begin
            dataValid_q <= 1'b0;
            if (stack_if.rst_stack) begin
                state_q        <= RUN;
                sp_q           <= '0;
                dataOut_q      <= '0;
                overflowErr_q  <= 1'b0;
                underflowErr_q <= 1'b0;
            end else if (state_q == RUN) begin
                case (cmd)
                    PUSH: begin
                        if (isFull) begin
                            overflowErr_q <= 1'b1;
                            state_q       <= FAULT;
                        end else begin
                            sp_q <= sp_q + PTR_W'(1);
                        end
                    end
                    POP: begin
                        if (isEmpty) begin
                            underflowErr_q <= 1'b1;
                            state_q        <= FAULT;
                        end else begin
                            dataOut_q   <= topData;
                            dataValid_q <= 1'b1;
                            sp_q        <= sp_q - PTR_W'(1);
                        end
                    end
                    REPLACE: begin
                        if (isEmpty) begin
                            underflowErr_q <= 1'b1;
                            state_q        <= FAULT;
                        end else begin
                            dataOut_q   <= topData;
                            dataValid_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign stack_if.data_out      = dataOut_q;
    assign stack_if.data_valid    = dataValid_q;
    assign stack_if.tos_pointer   = sp_q;
    assign stack_if.empty         = isEmpty;
    assign stack_if.full          = isFull;
    assign stack_if.overflow_err  = overflowErr_q;
    assign stack_if.underflow_err = underflowErr_q;
    assign stack_if.fault         = (state_q == FAULT);

endmodule

// File: tb/tb_data_stack_unit.sv
// Directed self-checking bench for data_stack_unit; peek checks run when DATA_STACK_PEEK_EN is defined.
module tb_data_stack_unit;

    logic clk = 1'b0;
    logic rst;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    data_stack_unit_if #(.WIDTH(16), .PTR_W(6)) stackBus ();

    data_stack_unit dut (
        .clk      (clk),
        .rst      (rst),
        .stack_if (stackBus)
    );

    // Holds a command for exactly one rising edge, then samples 1 time unit later.
    task automatic applyStimulus(input logic push, input logic pop, input logic clr,
                                 input logic [15:0] d);
        stackBus.push_stack = push;
        stackBus.pop_stack  = pop;
        stackBus.rst_stack  = clr;
        stackBus.stack_data = d;
        @(posedge clk);
        #1;
        stackBus.push_stack = 1'b0;
        stackBus.pop_stack  = 1'b0;
        stackBus.rst_stack  = 1'b0;
    endtask

    task automatic test_reset();
        testsRun++;
        if (stackBus.tos_pointer !== 6'd0 || stackBus.empty !== 1'b1 || stackBus.full !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ptr: got sp=%0d empty=%b full=%b, expected sp=0 empty=1 full=0",
                     stackBus.tos_pointer, stackBus.empty, stackBus.full);
        end
        testsRun++;
        if (stackBus.data_out !== 16'h0000 || stackBus.data_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: got data=%h valid=%b, expected 0000/0",
                     stackBus.data_out, stackBus.data_valid);
        end
        testsRun++;
        if ({stackBus.fault, stackBus.overflow_err, stackBus.underflow_err} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: got fault/ovf/unf=%b, expected 000",
                     {stackBus.fault, stackBus.overflow_err, stackBus.underflow_err});
        end
    endtask

    task automatic test_lifo();
        logic [15:0] expData [3] = '{16'h0003, 16'h0002, 16'h0001};
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0002);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0003);
        testsRun++;
        if (stackBus.tos_pointer !== 6'd3) begin
            testsFailed++;
            $display("[TB] FAIL lifo_sp3: got %0d, expected 3", stackBus.tos_pointer);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
            testsRun++;
            if (stackBus.data_out !== expData[i] || stackBus.data_valid !== 1'b1 ||
                stackBus.tos_pointer !== 6'(2 - i)) begin
                testsFailed++;
                $display("[TB] FAIL lifo_pop%0d: got data=%h valid=%b sp=%0d, expected %h/1/%0d",
                         i, stackBus.data_out, stackBus.data_valid, stackBus.tos_pointer,
                         expData[i], 2 - i);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        testsRun++;
        if (stackBus.empty !== 1'b1 || stackBus.data_valid !== 1'b0 || stackBus.data_out !== 16'h0001) begin
            testsFailed++;
            $display("[TB] FAIL lifo_idle: got empty=%b valid=%b data=%h, expected 1/0/0001",
                     stackBus.empty, stackBus.data_valid, stackBus.data_out);
        end
    endtask

    task automatic test_overflow();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i));
        end
        testsRun++;
        if (stackBus.full !== 1'b1 || stackBus.tos_pointer !== 6'd32 || stackBus.fault !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ovf_full: got full=%b sp=%0d fault=%b, expected 1/32/0",
                     stackBus.full, stackBus.tos_pointer, stackBus.fault);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hDEAD);
        testsRun++;
        if (stackBus.overflow_err !== 1'b1 || stackBus.fault !== 1'b1 || stackBus.tos_pointer !== 6'd32) begin
            testsFailed++;
            $display("[TB] FAIL ovf_push33: got ovf=%b fault=%b sp=%0d, expected 1/1/32",
                     stackBus.overflow_err, stackBus.fault, stackBus.tos_pointer);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        testsRun++;
        if (stackBus.data_valid !== 1'b0 || stackBus.data_out !== 16'h0000 || stackBus.tos_pointer !== 6'd32) begin
            testsFailed++;
            $display("[TB] FAIL ovf_frozen_pop: got valid=%b data=%h sp=%0d, expected 0/0000/32",
                     stackBus.data_valid, stackBus.data_out, stackBus.tos_pointer);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
        testsRun++;
        if (stackBus.fault !== 1'b0 || stackBus.overflow_err !== 1'b0 || stackBus.tos_pointer !== 6'd0) begin
            testsFailed++;
            $display("[TB] FAIL ovf_clear: got fault=%b ovf=%b sp=%0d, expected 0/0/0",
                     stackBus.fault, stackBus.overflow_err, stackBus.tos_pointer);
        end
    endtask

    task automatic test_underflow();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        testsRun++;
        if (stackBus.underflow_err !== 1'b1 || stackBus.fault !== 1'b1 ||
            stackBus.data_out !== 16'h0000 || stackBus.data_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL unf_pop: got unf=%b fault=%b data=%h valid=%b, expected 1/1/0000/0",
                     stackBus.underflow_err, stackBus.fault, stackBus.data_out, stackBus.data_valid);
        end
        // A push in the same cycle as rst_stack must be dropped.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h7777);
        testsRun++;
        if ({stackBus.fault, stackBus.overflow_err, stackBus.underflow_err} !== 3'b000 ||
            stackBus.tos_pointer !== 6'd0) begin
            testsFailed++;
            $display("[TB] FAIL unf_clear: got fault/ovf/unf=%b sp=%0d, expected 000/0",
                     {stackBus.fault, stackBus.overflow_err, stackBus.underflow_err},
                     stackBus.tos_pointer);
        end
    endtask

    task automatic test_replace();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hAAAA);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h5555);
        testsRun++;
        if (stackBus.data_out !== 16'hAAAA || stackBus.data_valid !== 1'b1 || stackBus.tos_pointer !== 6'd1) begin
            testsFailed++;
            $display("[TB] FAIL repl_swap: got data=%h valid=%b sp=%0d, expected AAAA/1/1",
                     stackBus.data_out, stackBus.data_valid, stackBus.tos_pointer);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        testsRun++;
        if (stackBus.data_out !== 16'h5555 || stackBus.empty !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL repl_pop: got data=%h empty=%b, expected 5555/1",
                     stackBus.data_out, stackBus.empty);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h9999);
        testsRun++;
        if (stackBus.underflow_err !== 1'b1 || stackBus.fault !== 1'b1 ||
            stackBus.data_out !== 16'h5555 || stackBus.tos_pointer !== 6'd0) begin
            testsFailed++;
            $display("[TB] FAIL repl_empty: got unf=%b fault=%b data=%h sp=%0d, expected 1/1/5555/0",
                     stackBus.underflow_err, stackBus.fault, stackBus.data_out, stackBus.tos_pointer);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        testsRun++;
        if (stackBus.data_out !== 16'h1234 || stackBus.data_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_raw: got data=%h valid=%b, expected 1234/1",
                     stackBus.data_out, stackBus.data_valid);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0040 + 16'(i));
        end
        testsRun++;
        if (stackBus.tos_pointer !== 6'd5) begin
            testsFailed++;
            $display("[TB] FAIL b2b_sp5: got %0d, expected 5", stackBus.tos_pointer);
        end
        #1;
        rst = 1'b1;
        #1;
        testsRun++;
        if (stackBus.tos_pointer !== 6'd0 || stackBus.empty !== 1'b1 ||
            stackBus.data_out !== 16'h0000 || stackBus.data_valid !== 1'b0 || stackBus.fault !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async_rst: got sp=%0d empty=%b data=%h valid=%b fault=%b, expected 0/1/0000/0/0",
                     stackBus.tos_pointer, stackBus.empty, stackBus.data_out,
                     stackBus.data_valid, stackBus.fault);
        end
        rst = 1'b0;
    endtask

`ifdef DATA_STACK_PEEK_EN
    task automatic test_peek();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
        testsRun++;
        if (stackBus.tos_peek !== 16'h0000 || stackBus.nos_peek !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL peek_empty: got tos=%h nos=%h, expected 0000/0000",
                     stackBus.tos_peek, stackBus.nos_peek);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0011);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0022);
        testsRun++;
        if (stackBus.tos_peek !== 16'h0022 || stackBus.nos_peek !== 16'h0011) begin
            testsFailed++;
            $display("[TB] FAIL peek_two: got tos=%h nos=%h, expected 0022/0011",
                     stackBus.tos_peek, stackBus.nos_peek);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        testsRun++;
        if (stackBus.tos_peek !== 16'h0011 || stackBus.nos_peek !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL peek_one: got tos=%h nos=%h, expected 0011/0000",
                     stackBus.tos_peek, stackBus.nos_peek);
        end
    endtask
`endif

    initial begin
        rst                 = 1'b1;
        stackBus.push_stack = 1'b0;
        stackBus.pop_stack  = 1'b0;
        stackBus.rst_stack  = 1'b0;
        stackBus.stack_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_replace();
        test_back_to_back();
`ifdef DATA_STACK_PEEK_EN
        test_peek();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
